// File: rtl/axi_bridge_pkg.sv
// Shared AXI definitions for the memory bridge: burst/response encodings,
// width helper and the tracker entry layouts.
package axi_bridge_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // Tracker fields are sized for the widest supported configuration.
    localparam int TRK_LANE_W = 8;
    localparam int TRK_ID_W   = 8;

    typedef struct packed {
        logic [TRK_LANE_W-1:0] lane;
        logic [2:0]            size;
        burst_e                burst;
    } wtrk_entry_t;

    typedef struct packed {
        logic [TRK_ID_W-1:0]   id;
        logic [TRK_LANE_W-1:0] lane;
        logic [2:0]            size;
        burst_e                burst;
    } rtrk_entry_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_mem_remap_upsizer_if.sv
// AXI4 bus bundle used on both sides of the bridge; widths set per instance.
interface axi_mem_remap_upsizer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic              aw_valid, aw_ready, aw_lock;
    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size, aw_prot;
    logic [1:0]        aw_burst;
    logic [3:0]        aw_cache, aw_qos;

    logic                w_valid, w_ready, w_last;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;

    logic            b_valid, b_ready;
    logic [ID_W-1:0] b_id;
    logic [1:0]      b_resp;

    logic              ar_valid, ar_ready, ar_lock;
    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size, ar_prot;
    logic [1:0]        ar_burst;
    logic [3:0]        ar_cache, ar_qos;

    logic              r_valid, r_ready, r_last;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last,
        input  r_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO without bypass: a push into a full FIFO is refused even
// when a pop happens in the same cycle.
module sync_fifo
    import axi_bridge_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok_s, pop_ok_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(32'd1);
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(32'd1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CNT_W'(32'd1);
                2'b01:   count_q <= count_q - CNT_W'(32'd1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/axi_mem_remap_upsizer.sv
// Narrow-to-wide AXI4 memory bridge: address-window remap, byte-lane steering
// of narrow beats on the wide bus, and in-order ID restoration via trackers.
module axi_mem_remap_upsizer
    import axi_bridge_pkg::*;
#(
    parameter int                    NARROW_DATA_W   = 64,
    parameter int                    WIDE_DATA_W     = 128,
    parameter int                    ID_W            = 4,
    parameter int                    OUT_ID_W        = 6,
    parameter int                    IN_ADDR_W       = 32,
    parameter int                    OUT_ADDR_W      = 49,
    parameter int                    WINDOW_BITS     = 28,
    parameter logic [OUT_ADDR_W-1:0] REMAP_BASE      = 49'h1000_0000,
    parameter int                    MAX_OUTSTANDING = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    axi_mem_remap_upsizer_if.slave  s,
    axi_mem_remap_upsizer_if.master m,
    output logic                    err_proto
);
    localparam int LANES  = WIDE_DATA_W / NARROW_DATA_W;
    localparam int NB_W   = clog2(NARROW_DATA_W / 8);
    localparam int NDB_W  = clog2(NARROW_DATA_W);
    localparam int OFF_W  = clog2(WIDE_DATA_W / 8);
    localparam int LANE_W = (LANES > 1) ? clog2(LANES) : 1;
    localparam int WSTRB  = WIDE_DATA_W / 8;
    localparam int CNT_W  = clog2(MAX_OUTSTANDING) + 1;

    logic              run_s, aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic              wl_full_s, wl_empty_s, bid_full_s, bid_empty_s, rd_full_s, rd_empty_s;
    wtrk_entry_t       wl_push_s, wl_head_s;
    rtrk_entry_t       rd_push_s, rd_head_s;
    logic [ID_W-1:0]   bid_head_s;
    logic [OFF_W-1:0]  w_adv_q, w_adv_d, r_adv_q, r_adv_d;
    logic [OFF_W-1:0]  w_off_s, r_off_s, w_step_s, r_step_s;
    logic [LANE_W-1:0] w_lane_s, r_lane_s;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  unused_wl_cnt_s, unused_bid_cnt_s, unused_rd_cnt_s;
    logic              unused_s;

    // While reset is held every valid and ready is forced low
    assign run_s = reset;

    assign m.aw_addr  = {REMAP_BASE[OUT_ADDR_W-1:WINDOW_BITS], s.aw_addr[WINDOW_BITS-1:0]};
    assign m.aw_id    = {OUT_ID_W{1'b0}};
    assign m.aw_len   = s.aw_len;
    assign m.aw_size  = s.aw_size;
    assign m.aw_burst = s.aw_burst;
    assign m.aw_lock  = s.aw_lock;
    assign m.aw_cache = s.aw_cache;
    assign m.aw_prot  = s.aw_prot;
    assign m.aw_qos   = s.aw_qos;
    assign m.aw_valid = run_s & s.aw_valid & ~wl_full_s & ~bid_full_s;
    assign s.aw_ready = run_s & m.aw_ready & ~wl_full_s & ~bid_full_s;
    assign aw_hs_s    = s.aw_valid & s.aw_ready;
    assign wl_push_s  = '{lane: TRK_LANE_W'(s.aw_addr[OFF_W-1:0] >> NB_W),
                          size: s.aw_size, burst: burst_e'(s.aw_burst)};

    assign m.ar_addr  = {REMAP_BASE[OUT_ADDR_W-1:WINDOW_BITS], s.ar_addr[WINDOW_BITS-1:0]};
    assign m.ar_id    = {OUT_ID_W{1'b0}};
    assign m.ar_len   = s.ar_len;
    assign m.ar_size  = s.ar_size;
    assign m.ar_burst = s.ar_burst;
    assign m.ar_lock  = s.ar_lock;
    assign m.ar_cache = s.ar_cache;
    assign m.ar_prot  = s.ar_prot;
    assign m.ar_qos   = s.ar_qos;
    assign m.ar_valid = run_s & s.ar_valid & ~rd_full_s;
    assign s.ar_ready = run_s & m.ar_ready & ~rd_full_s;
    assign ar_hs_s    = s.ar_valid & s.ar_ready;
    assign rd_push_s  = '{id: TRK_ID_W'(s.ar_id), lane: TRK_LANE_W'(s.ar_addr[OFF_W-1:0] >> NB_W),
                          size: s.ar_size, burst: burst_e'(s.ar_burst)};

    // Lane = (start lane byte offset + bytes advanced so far) mod wide width; FIXED never advances
    assign w_step_s = (wl_head_s.burst == BURST_FIXED) ? {OFF_W{1'b0}} : (OFF_W'(32'd1) << wl_head_s.size);
    assign w_off_s  = (OFF_W'(wl_head_s.lane[LANE_W-1:0]) << NB_W) + w_adv_q;
    assign w_lane_s = LANE_W'(w_off_s >> NB_W);
    assign r_step_s = (rd_head_s.burst == BURST_FIXED) ? {OFF_W{1'b0}} : (OFF_W'(32'd1) << rd_head_s.size);
    assign r_off_s  = (OFF_W'(rd_head_s.lane[LANE_W-1:0]) << NB_W) + r_adv_q;
    assign r_lane_s = LANE_W'(r_off_s >> NB_W);

    assign m.w_valid = run_s & s.w_valid & ~wl_empty_s;
    assign s.w_ready = run_s & m.w_ready & ~wl_empty_s;
    assign m.w_data  = {LANES{s.w_data}};
    assign m.w_strb  = WSTRB'(s.w_strb) << {w_lane_s, {NB_W{1'b0}}};
    assign m.w_last  = s.w_last;
    assign w_hs_s    = s.w_valid & s.w_ready;

    // Responses with no matching tracker entry are swallowed and flagged
    assign s.b_valid = run_s & m.b_valid & ~bid_empty_s;
    assign m.b_ready = run_s & (bid_empty_s | s.b_ready);
    assign s.b_id    = bid_head_s;
    assign s.b_resp  = m.b_resp;
    assign b_hs_s    = s.b_valid & s.b_ready;

    assign s.r_valid = run_s & m.r_valid & ~rd_empty_s;
    assign m.r_ready = run_s & (rd_empty_s | s.r_ready);
    assign s.r_id    = rd_head_s.id[ID_W-1:0];
    assign s.r_data  = NARROW_DATA_W'(m.r_data >> {r_lane_s, {NDB_W{1'b0}}});
    assign s.r_resp  = m.r_resp;
    assign s.r_last  = m.r_last;
    assign r_hs_s    = s.r_valid & s.r_ready;

    assign err_proto = err_q;
    assign unused_s  = ^{wl_head_s.lane, rd_head_s.id, rd_head_s.lane, m.b_id, m.r_id,
                         s.aw_addr[IN_ADDR_W-1:0], s.ar_addr[IN_ADDR_W-1:0]};

    // Next-state for per-burst byte advance and the sticky protocol error
    always_comb begin
        w_adv_d = w_adv_q;
        r_adv_d = r_adv_q;
        err_d   = err_q;
        if (w_hs_s) begin
            w_adv_d = s.w_last ? {OFF_W{1'b0}} : (w_adv_q + w_step_s);
        end else begin
            w_adv_d = w_adv_q;
        end
        if (r_hs_s) begin
            r_adv_d = s.r_last ? {OFF_W{1'b0}} : (r_adv_q + r_step_s);
        end else begin
            r_adv_d = r_adv_q;
        end
        if (run_s && ((m.b_valid && bid_empty_s) || (m.r_valid && rd_empty_s))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            w_adv_q <= {OFF_W{1'b0}};
            r_adv_q <= {OFF_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            w_adv_q <= w_adv_d;
            r_adv_q <= r_adv_d;
            err_q   <= err_d;
        end
    end

    sync_fifo #(.WIDTH($bits(wtrk_entry_t)), .DEPTH(MAX_OUTSTANDING)) u_wlane_fifo (
        .clk_i(clock), .rst_ni(reset), .push_i(aw_hs_s), .data_i(wl_push_s),
        .pop_i(w_hs_s & s.w_last), .data_o(wl_head_s), .full_o(wl_full_s),
        .empty_o(wl_empty_s), .count_o(unused_wl_cnt_s)
    );

    sync_fifo #(.WIDTH(ID_W), .DEPTH(MAX_OUTSTANDING)) u_bid_fifo (
        .clk_i(clock), .rst_ni(reset), .push_i(aw_hs_s), .data_i(s.aw_id),
        .pop_i(b_hs_s), .data_o(bid_head_s), .full_o(bid_full_s),
        .empty_o(bid_empty_s), .count_o(unused_bid_cnt_s)
    );

    sync_fifo #(.WIDTH($bits(rtrk_entry_t)), .DEPTH(MAX_OUTSTANDING)) u_rd_fifo (
        .clk_i(clock), .rst_ni(reset), .push_i(ar_hs_s), .data_i(rd_push_s),
        .pop_i(r_hs_s & s.r_last), .data_o(rd_head_s), .full_o(rd_full_s),
        .empty_o(rd_empty_s), .count_o(unused_rd_cnt_s)
    );
endmodule

// File: tb/tb_axi_mem_remap_upsizer.sv
// Directed self-checking bench for axi_mem_remap_upsizer with scoreboard queues.
module tb_axi_mem_remap_upsizer;
    import axi_bridge_pkg::*;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic        last;
    } r_exp_t;

    logic clock = 1'b0;
    logic reset;
    logic err_proto;
    int   checks = 0;
    int   errors = 0;

    r_exp_t      r_exp_q[$];
    logic [15:0] strb_exp_q[$];
    logic [3:0]  bid_exp_q[$];

    axi_mem_remap_upsizer_if #(.ADDR_W(32), .DATA_W(64),  .ID_W(4)) s_if ();
    axi_mem_remap_upsizer_if #(.ADDR_W(49), .DATA_W(128), .ID_W(6)) m_if ();

    axi_mem_remap_upsizer dut (
        .clock(clock), .reset(reset), .s(s_if), .m(m_if), .err_proto(err_proto)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic init_inputs();
        s_if.aw_valid = 1'b0; s_if.aw_id = 4'h0; s_if.aw_addr = 32'h0; s_if.aw_len = 8'h0;
        s_if.aw_size = 3'd3; s_if.aw_burst = 2'b01; s_if.aw_lock = 1'b0; s_if.aw_cache = 4'h0;
        s_if.aw_prot = 3'd0; s_if.aw_qos = 4'h0;
        s_if.w_valid = 1'b0; s_if.w_data = 64'h0; s_if.w_strb = 8'h0; s_if.w_last = 1'b0;
        s_if.b_ready = 1'b1;
        s_if.ar_valid = 1'b0; s_if.ar_id = 4'h0; s_if.ar_addr = 32'h0; s_if.ar_len = 8'h0;
        s_if.ar_size = 3'd3; s_if.ar_burst = 2'b01; s_if.ar_lock = 1'b0; s_if.ar_cache = 4'h0;
        s_if.ar_prot = 3'd0; s_if.ar_qos = 4'h0;
        s_if.r_ready = 1'b1;
        m_if.aw_ready = 1'b1; m_if.w_ready = 1'b1; m_if.ar_ready = 1'b1;
        m_if.b_valid = 1'b0; m_if.b_id = 6'h0; m_if.b_resp = 2'b00;
        m_if.r_valid = 1'b0; m_if.r_id = 6'h0; m_if.r_data = 128'h0; m_if.r_resp = 2'b00;
        m_if.r_last = 1'b0;
    endtask

    task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        s_if.ar_valid = 1'b1; s_if.ar_id = id; s_if.ar_addr = addr; s_if.ar_len = len;
        s_if.ar_size = 3'd3; s_if.ar_burst = burst; s_if.ar_cache = 4'h3; s_if.ar_qos = 4'h2;
    endtask

    task automatic drive_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        s_if.aw_valid = 1'b1; s_if.aw_id = id; s_if.aw_addr = addr; s_if.aw_len = len;
        s_if.aw_size = 3'd3; s_if.aw_burst = 2'b01; s_if.aw_cache = 4'h3;
    endtask

    task automatic drive_r(input logic [127:0] data, input logic last);
        m_if.r_valid = 1'b1; m_if.r_data = data; m_if.r_last = last; m_if.r_id = 6'h2A;
    endtask

    task automatic check_r(input string tag);
        r_exp_t e;
        chk({tag, "_valid"}, 128'(s_if.r_valid), 128'(1'b1));
        e = r_exp_q.pop_front();
        chk({tag, "_id"},   128'(s_if.r_id),   128'(e.id));
        chk({tag, "_data"}, 128'(s_if.r_data), 128'(e.data));
        chk({tag, "_last"}, 128'(s_if.r_last), 128'(e.last));
    endtask

    task automatic check_w(input string tag, input logic [63:0] data, input logic last);
        chk({tag, "_valid"}, 128'(m_if.w_valid), 128'(1'b1));
        chk({tag, "_strb"},  128'(m_if.w_strb),  128'(strb_exp_q.pop_front()));
        chk({tag, "_data"},  128'(m_if.w_data),  {data, data});
        chk({tag, "_last"},  128'(m_if.w_last),  128'(last));
    endtask

    task automatic check_b(input string tag, input logic [1:0] resp);
        chk({tag, "_valid"}, 128'(s_if.b_valid), 128'(1'b1));
        chk({tag, "_id"},    128'(s_if.b_id),    128'(bid_exp_q.pop_front()));
        chk({tag, "_resp"},  128'(s_if.b_resp),  128'(resp));
    endtask

    initial begin
        logic [63:0] low;
        reset = 1'b0;
        init_inputs();
        tick();
        tick();

        // Reset state: even with responses arriving, nothing reaches upstream
        m_if.b_valid = 1'b1; m_if.r_valid = 1'b1; s_if.w_valid = 1'b1;
        #1;
        chk("rst_s_b_valid", 128'(s_if.b_valid), 128'(1'b0));
        chk("rst_s_r_valid", 128'(s_if.r_valid), 128'(1'b0));
        chk("rst_m_w_valid", 128'(m_if.w_valid), 128'(1'b0));
        chk("rst_err",       128'(err_proto),    128'(1'b0));
        m_if.b_valid = 1'b0; m_if.r_valid = 1'b0; s_if.w_valid = 1'b0;
        reset = 1'b1;
        tick();

        // W with no outstanding AW is held off
        s_if.w_valid = 1'b1; s_if.w_strb = 8'hFF; s_if.w_last = 1'b1;
        #1;
        chk("w_noaw_valid", 128'(m_if.w_valid), 128'(1'b0));
        chk("w_noaw_ready", 128'(s_if.w_ready), 128'(1'b0));
        s_if.w_valid = 1'b0; s_if.w_last = 1'b0;

        // Remap and ID restore on a single-beat read
        drive_ar(4'h5, 32'h8000_1240, 8'd0, 2'b01);
        #1;
        chk("ar_addr",  128'(m_if.ar_addr),  128'(49'h1000_1240));
        chk("ar_id",    128'(m_if.ar_id),    128'(6'h0));
        chk("ar_valid", 128'(m_if.ar_valid), 128'(1'b1));
        chk("ar_cache", 128'(m_if.ar_cache), 128'(4'h3));
        r_exp_q.push_back('{id: 4'h5, data: 64'h1111_2222_3333_4444, last: 1'b1});
        tick();
        s_if.ar_valid = 1'b0;
        drive_r({64'hDEAD_BEEF_0000_0001, 64'h1111_2222_3333_4444}, 1'b1);
        #1;
        check_r("rd_remap");
        tick();
        m_if.r_valid = 1'b0;

        // Write lane steering: INCR from lane 1 wraps onto lane 0
        drive_aw(4'h2, 32'h8000_0008, 8'd1);
        #1;
        chk("aw_addr", 128'(m_if.aw_addr), 128'(49'h1000_0008));
        chk("aw_id",   128'(m_if.aw_id),   128'(6'h0));
        strb_exp_q.push_back(16'hFF00);
        strb_exp_q.push_back(16'h00FF);
        bid_exp_q.push_back(4'h2);
        tick();
        s_if.aw_valid = 1'b0;
        s_if.w_valid = 1'b1; s_if.w_strb = 8'hFF; s_if.w_data = 64'h0123_4567_89AB_CDEF; s_if.w_last = 1'b0;
        #1;
        check_w("w_beat0", 64'h0123_4567_89AB_CDEF, 1'b0);
        tick();
        s_if.w_data = 64'hFEDC_BA98_7654_3210; s_if.w_last = 1'b1;
        #1;
        check_w("w_beat1", 64'hFEDC_BA98_7654_3210, 1'b1);
        tick();
        s_if.w_valid = 1'b0; s_if.w_last = 1'b0;
        m_if.b_valid = 1'b1; m_if.b_resp = 2'b00; m_if.b_id = 6'h3F;
        #1;
        check_b("b_steer", 2'b00);
        tick();
        m_if.b_valid = 1'b0;

        // FIXED read from lane 1: every beat returns the upper half
        drive_ar(4'h9, 32'h8000_0008, 8'd3, 2'b00);
        for (int i = 0; i < 4; i++)
            r_exp_q.push_back('{id: 4'h9, data: 64'hA5A5_A5A5_A5A5_A5A5, last: (i == 3)});
        tick();
        s_if.ar_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_r({64'hA5A5_A5A5_A5A5_A5A5, 64'h0 | 64'(i)}, (i == 3));
            #1;
            check_r("rd_fixed");
            tick();
        end
        m_if.r_valid = 1'b0;

        // Outstanding limit: eight reads fill the tracker, the ninth is refused
        for (int i = 0; i < 8; i++) begin
            drive_ar(4'(i), 32'h8000_0000 + 32'(i * 16), 8'd0, 2'b01);
            #1;
            chk("ar_fill_ready", 128'(s_if.ar_ready), 128'(1'b1));
            r_exp_q.push_back('{id: 4'(i), data: 64'hC0DE_0000_0000_0000 | 64'(i), last: 1'b1});
            tick();
        end
        drive_ar(4'h8, 32'h8000_0100, 8'd0, 2'b01);
        #1;
        chk("ar_full_ready", 128'(s_if.ar_ready), 128'(1'b0));
        chk("ar_full_valid", 128'(m_if.ar_valid), 128'(1'b0));
        drive_r({64'h0BAD_0BAD_0BAD_0BAD, 64'hC0DE_0000_0000_0000}, 1'b1);
        #1;
        check_r("rd_full_ret");
        tick();
        m_if.r_valid = 1'b0;
        #1;
        chk("ar_after_pop_ready", 128'(s_if.ar_ready), 128'(1'b1));
        r_exp_q.push_back('{id: 4'h8, data: 64'hC0DE_0000_0000_0008, last: 1'b1});
        tick();
        s_if.ar_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            low = 64'hC0DE_0000_0000_0000 | 64'(k);
            drive_r({32'($urandom), 32'($urandom), low}, 1'b1);
            #1;
            check_r("rd_drain");
            tick();
        end
        m_if.r_valid = 1'b0;

        // Ordering: three writes, responses must restore ids in issue order
        for (int k = 0; k < 3; k++) begin
            drive_aw((k == 0) ? 4'h3 : (k == 1) ? 4'h7 : 4'h1, 32'h8000_0000 + 32'(k * 16), 8'd0);
            bid_exp_q.push_back((k == 0) ? 4'h3 : (k == 1) ? 4'h7 : 4'h1);
            strb_exp_q.push_back(16'h00FF);
            tick();
        end
        s_if.aw_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_if.w_valid = 1'b1; s_if.w_data = 64'h5555_0000_0000_0000 | 64'(k); s_if.w_last = 1'b1;
            #1;
            check_w("w_order", 64'h5555_0000_0000_0000 | 64'(k), 1'b1);
            tick();
        end
        s_if.w_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_if.b_valid = 1'b1; m_if.b_resp = 2'(k); m_if.b_id = 6'h0;
            #1;
            check_b("b_order", 2'(k));
            tick();
        end
        m_if.b_valid = 1'b0;

        // Response with an empty tracker is swallowed and flagged
        m_if.b_valid = 1'b1;
        #1;
        chk("orphan_b_ready", 128'(m_if.b_ready), 128'(1'b1));
        chk("orphan_s_valid", 128'(s_if.b_valid), 128'(1'b0));
        tick();
        m_if.b_valid = 1'b0;
        #1;
        chk("orphan_err", 128'(err_proto), 128'(1'b1));

        // Reset during the second W beat abandons the burst
        drive_aw(4'h4, 32'h8000_0000, 8'd1);
        strb_exp_q.push_back(16'h00FF);
        strb_exp_q.push_back(16'hFF00);
        bid_exp_q.push_back(4'h4);
        tick();
        s_if.aw_valid = 1'b0;
        s_if.w_valid = 1'b1; s_if.w_data = 64'h7777_7777_7777_7777; s_if.w_last = 1'b0;
        #1;
        check_w("w_pre_rst", 64'h7777_7777_7777_7777, 1'b0);
        tick();
        s_if.w_last = 1'b1;
        reset = 1'b0;
        tick();
        m_if.b_valid = 1'b1;
        #1;
        chk("mid_rst_w_valid", 128'(m_if.w_valid), 128'(1'b0));
        chk("mid_rst_b_valid", 128'(s_if.b_valid), 128'(1'b0));
        chk("mid_rst_err",     128'(err_proto),    128'(1'b0));
        strb_exp_q.delete();
        bid_exp_q.delete();
        m_if.b_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("post_rst_w_valid", 128'(m_if.w_valid), 128'(1'b0));
        s_if.w_valid = 1'b0; s_if.w_last = 1'b0;
        tick();
        drive_aw(4'hA, 32'h8000_0008, 8'd0);
        strb_exp_q.push_back(16'hFF00);
        bid_exp_q.push_back(4'hA);
        tick();
        s_if.aw_valid = 1'b0;
        s_if.w_valid = 1'b1; s_if.w_data = 64'h9999_0000_1111_2222; s_if.w_last = 1'b1;
        #1;
        check_w("w_fresh", 64'h9999_0000_1111_2222, 1'b1);
        tick();
        s_if.w_valid = 1'b0; s_if.w_last = 1'b0;
        m_if.b_valid = 1'b1; m_if.b_resp = 2'b00;
        #1;
        check_b("b_fresh", 2'b00);
        tick();
        m_if.b_valid = 1'b0;
        #1;
        chk("fresh_err", 128'(err_proto), 128'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_mem_remap_upsizer.md
Name: axi_mem_remap_upsizer

Overview:
- Parametrised bridge between the core's narrow AXI4 memory master and the PS DDR slave port.
- Replaces the fixed address splice and lower-half data wiring with three functions:
  - configurable address-window remap;
  - correct byte-lane steering of narrow beats onto the wide bus;
  - ID re-mapping through ordered trackers, so downstream responses return in order and original IDs are restored.
- No beat packing: one narrow beat always maps to one wide beat, and burst length is unchanged.

Parameters:
- NARROW_DATA_W, 64, upstream data width (bits)
- WIDE_DATA_W, 128, downstream data width; integer multiple of NARROW_DATA_W
- ID_W, 4, upstream AXI ID width
- OUT_ID_W, 6, downstream AXI ID width; always driven to 0
- IN_ADDR_W, 32, upstream address width
- OUT_ADDR_W, 49, downstream address width
- WINDOW_BITS, 28, low address bits passed through unchanged
- REMAP_BASE, 49'h1000_0000, downstream base address; bits below WINDOW_BITS are ignored
- MAX_OUTSTANDING, 8, depth of each tracker (read, write-lane, write-response); power of 2

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-low reset
- s_aw_{valid,ready,id,addr,len,size,burst,lock,cache,prot,qos}  in/out  AXI4  upstream AW; addr IN_ADDR_W
- s_w_{valid,ready,data,strb,last}  in/out  NARROW_DATA_W, NARROW_DATA_W/8  upstream W
- s_b_{valid,ready,id,resp}  out/in  ID_W, 2  upstream B
- s_ar_* (same fields as s_aw_*)  in/out  AXI4  upstream AR
- s_r_{valid,ready,id,data,resp,last}  out/in  NARROW_DATA_W  upstream R
- m_aw_*, m_w_*, m_b_*, m_ar_*, m_r_*  mirror of s_*  addr OUT_ADDR_W, data WIDE_DATA_W, id OUT_ID_W  downstream
- err_proto  out  1  sticky; set on any response arriving while its tracker is empty

Behaviour:
- Address remap, combinational: m_addr = {REMAP_BASE[OUT_ADDR_W-1:WINDOW_BITS], s_addr[WINDOW_BITS-1:0]}.
- Passthrough fields: len, size, burst, lock, cache, prot and qos pass unchanged. m_aw_id and m_ar_id are driven to 0.
- Lane index: LANES = WIDE_DATA_W/NARROW_DATA_W. lane = addr[log2(WIDE_DATA_W/8)-1 : log2(NARROW_DATA_W/8)].
- AW path, 0-cycle forward:
  - m_aw_valid = s_aw_valid & !wlane_full & !bid_full.
  - s_aw_ready = m_aw_ready & !wlane_full & !bid_full.
  - On handshake: push {lane, size, burst} into the write-lane FIFO and push id into the B-ID FIFO.
- W path:
  - Beats pass only while the write-lane FIFO is non-empty; otherwise m_w_valid = 0 and s_w_ready = 0.
  - Data is replicated across all lanes.
  - m_w_strb is s_w_strb placed at the current lane, with all other lanes zero.
  - INCR beats: a byte-offset counter advances by 2^size per beat, modulo WIDE_DATA_W/8, and lane is derived from it.
  - FIXED beats: lane does not advance.
  - WRAP beats are steered as INCR.
  - On the s_w_last handshake: pop the lane FIFO and reload the counter from the next entry.
- B path:
  - s_b_valid = m_b_valid & !bid_empty; s_b_id = head of B-ID FIFO; pop on handshake.
- AR path: same gating against the read tracker. Push {id, lane, size, burst} on handshake.
- R path:
  - s_r_data = selected lane of m_r_data; steering identical to W.
  - s_r_id restored from the tracker head; pop on the s_r_last handshake.
- Response on empty tracker: m_r_valid or m_b_valid with its tracker empty sets err_proto; the beat is accepted (ready = 1) and dropped.
- FIFO boundaries:
  - No bypass: a push into a full FIFO is refused even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Reset (reset == 0 at clock edge):
  - All FIFOs emptied; lane counters set to 0; err_proto = 0.
  - All m_*_valid and s_*_valid outputs = 0.
  - Reset mid-burst abandons outstanding transactions; no recovery is attempted.

Decomposition:
- Shared package axi_bridge_pkg:
  - AXI burst encodings (FIXED/INCR/WRAP) and resp codes.
  - Lane-width function clog2.
  - Tracker entry struct types {id, lane, size, burst}.
- One sub-module: sync_fifo (parametrised WIDTH/DEPTH, full/empty/count, synchronous active-low reset). Instantiated three times.

Test Plan:
- Remap: AR addr 0x8000_1240 -> m_ar_addr = 0x1000_1240; m_ar_id = 0; s_r_id restored to the issued value 0x5.
- Write lane steering: AW addr 0x8000_0008, size 3, len 1, INCR; beats strb 0xFF, 0xFF -> m_w_strb 0xFF00 then 0x00FF (wrap onto lane 0).
- FIXED read: AR addr 0x8000_0008, len 3, FIXED; m_r_data upper half = 0xA5 pattern -> all 4 s_r_data beats = upper half.
- Outstanding limit: issue 8 ARs with no R response -> 9th sees s_ar_ready = 0. Return one burst -> s_ar_ready = 1 the next cycle.
- Ordering/ID restore: AW ids 3, 7, 1 -> three m_b responses -> s_b_id sequence 3, 7, 1.
- Reset mid-burst: drop reset during the 2nd W beat -> next cycle all valids = 0, trackers empty. A fresh AW/W completes normally with err_proto = 0.
